// File: rtl/output_allocator_pkg.sv
// Shared NoC definitions for the output allocator: FSM state encoding and
// width helpers used by the allocator, its interface and its arbiter.
package output_allocator_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_t;

   // Counter width able to hold 0..depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/output_allocator_if.sv
// Flit handshake between the input ports and one output allocator:
// per-input requests/tails and credit return in, grants and flit valid out.
interface output_allocator_if
   import output_allocator_pkg::*;
#(
   parameter int NUM_INPUTS = 2
);

   localparam int SEL_W = sel_w(NUM_INPUTS);

   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] is_tail;
   logic                  credit_in;
   logic [NUM_INPUTS-1:0] grant;
   logic [SEL_W-1:0]      sel;
   logic                  send_out;

   modport master (
      output req, is_tail, credit_in,
      input  grant, sel, send_out
   );

   modport slave (
      input  req, is_tail, credit_in,
      output grant, sel, send_out
   );

endinterface

// File: rtl/output_allocator_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping, returned as a one-hot grant plus its index.
module rr_arbiter
   import output_allocator_pkg::*;
#(
   parameter int NUM_INPUTS = 2
) (
   input  logic [NUM_INPUTS-1:0]          req,
   input  logic [sel_w(NUM_INPUTS)-1:0]   rr_ptr,
   output logic [NUM_INPUTS-1:0]          gnt,
   output logic [sel_w(NUM_INPUTS)-1:0]   idx
);

   localparam int SEL_W = sel_w(NUM_INPUTS);

   always_comb begin
      int   j;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = SEL_W'(j);
         end
      end
   end

endmodule

// File: rtl/output_allocator.sv
// Credit-based output allocator: round-robin among inputs between packets,
// locked to one owner for the duration of a multi-flit packet.
module output_allocator
   import output_allocator_pkg::*;
#(
   parameter int NUM_INPUTS        = 2,
   parameter int FLIT_BUFFER_DEPTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   output_allocator_if.slave                      bus,
   output logic                                   locked,
   output logic [credit_w(FLIT_BUFFER_DEPTH)-1:0] credit_count,
   output logic                                   credit_overflow
);

   localparam int              SEL_W = sel_w(NUM_INPUTS);
   localparam int              CW    = credit_w(FLIT_BUFFER_DEPTH);
   localparam logic [CW-1:0]   FULL  = CW'(FLIT_BUFFER_DEPTH);

   alloc_state_t          state, state_n;
   logic [SEL_W-1:0]      owner, owner_n;
   logic [SEL_W-1:0]      rr_ptr, rr_ptr_n;
   logic [NUM_INPUTS-1:0] arb_gnt;
   logic [SEL_W-1:0]      arb_idx;

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
      if (int'(i) >= NUM_INPUTS - 1) return '0;
      return i + SEL_W'(1);
   endfunction

   rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_rr_arbiter (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .gnt    (arb_gnt),
      .idx    (arb_idx)
   );

   // Grant is combinational from registered credit, so a returned credit
   // can only be spent from the following cycle on.
   always_comb begin
      bus.grant    = '0;
      bus.sel      = '0;
      state_n      = state;
      owner_n      = owner;
      rr_ptr_n     = rr_ptr;
      if (rst_n && (credit_count != '0)) begin
         if (state == IDLE) begin
            bus.grant = arb_gnt;
            bus.sel   = arb_idx;
         end else if (bus.req[owner]) begin
            bus.grant[owner] = 1'b1;
            bus.sel          = owner;
         end
      end
      bus.send_out = |bus.grant;
      if (bus.send_out) begin
         if (bus.is_tail[bus.sel]) begin
            state_n  = IDLE;
            rr_ptr_n = wrap_inc(bus.sel);
         end else if (state == IDLE) begin
            state_n = LOCKED;
            owner_n = bus.sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         owner           <= '0;
         rr_ptr          <= '0;
         credit_count    <= FULL;
         credit_overflow <= 1'b0;
      end else begin
         state  <= state_n;
         owner  <= owner_n;
         rr_ptr <= rr_ptr_n;
         case ({bus.send_out, bus.credit_in})
            2'b10:   credit_count <= credit_count - CW'(1);
            2'b01: begin
               if (credit_count == FULL) credit_overflow <= 1'b1;
               else                      credit_count    <= credit_count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign locked = (state == LOCKED);

endmodule
